// File: rtl/mem_stage.sv
// mem_stage: memory-access stage with word-addressed data RAM, wait states and registered write-back.
module mem_stage #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  issueValid,
    input  logic                  memReadFlag,
    input  logic                  memWriteFlag,
    input  logic                  memToRegFlag,
    input  logic                  regWriteIn,
    input  logic [4:0]            writeRegIn,
    input  logic [DATA_WIDTH-1:0] aluResult,
    input  logic [DATA_WIDTH-1:0] storeData,
    output logic                  stall,
    output logic                  wbValid,
    output logic [DATA_WIDTH-1:0] wbData,
    output logic [4:0]            wbRegister,
    output logic                  wbRegWrite,
    output logic                  misalignedFlag
);
    localparam int CW = WAIT_STATES > 0 ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state;
    logic [CW-1:0]           count;
    logic [ADDR_WIDTH-1:0]   l_addr;
    logic [DATA_WIDTH-1:0]   l_data;
    logic [DATA_WIDTH-1:0]   l_alu;
    logic [4:0]              l_reg;
    logic                    l_m2r;
    logic                    l_rw;
    logic                    l_rd;
    logic                    l_wr;
    logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH] = '{default: '0};

    assign stall = (state == BUSY);

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state          <= IDLE;
            count          <= '0;
            wbValid        <= 1'b0;
            wbData         <= '0;
            wbRegister     <= '0;
            wbRegWrite     <= 1'b0;
            misalignedFlag <= 1'b0;
        end else begin
            wbValid        <= 1'b0;
            misalignedFlag <= 1'b0;
            if (state == IDLE && issueValid) begin
                if (!(memReadFlag || memWriteFlag)) begin
                    wbValid    <= 1'b1;
                    wbData     <= aluResult;
                    wbRegister <= writeRegIn;
                    wbRegWrite <= regWriteIn;
                end else if (aluResult[1:0] != 2'b00) begin
                    wbValid        <= 1'b1;
                    misalignedFlag <= 1'b1;
                    wbData         <= aluResult;
                    wbRegister     <= writeRegIn;
                    wbRegWrite     <= 1'b0;
                end else begin
                    l_addr <= aluResult[ADDR_WIDTH+1:2];
                    l_data <= storeData;
                    l_alu  <= aluResult;
                    l_reg  <= writeRegIn;
                    l_m2r  <= memToRegFlag;
                    l_rw   <= regWriteIn;
                    l_rd   <= memReadFlag;
                    l_wr   <= memWriteFlag;
                    count  <= CW'(WAIT_STATES);
                    state  <= BUSY;
                end
            end else if (state == BUSY) begin
                if (count != '0) begin
                    count <= count - 1'b1;
                end else begin
                    // read uses the pre-write word when both flags are set
                    if (l_wr) mem[l_addr] <= l_data;
                    wbData     <= (l_rd && l_m2r) ? mem[l_addr] : l_alu;
                    wbRegister <= l_reg;
                    wbRegWrite <= l_rd ? l_rw : 1'b0;
                    wbValid    <= 1'b1;
                    state      <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage with WAIT_STATES=2.
module tb_mem_stage;
    logic        clock = 1'b0;
    logic        resetN;
    logic        issueValid;
    logic        memReadFlag;
    logic        memWriteFlag;
    logic        memToRegFlag;
    logic        regWriteIn;
    logic [4:0]  writeRegIn;
    logic [31:0] aluResult;
    logic [31:0] storeData;
    logic        stall;
    logic        wbValid;
    logic [31:0] wbData;
    logic [4:0]  wbRegister;
    logic        wbRegWrite;
    logic        misalignedFlag;

    int tests = 0;
    int fails = 0;
    int n;
    bit seen7;

    mem_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_STATES(2)) dut (
        .clock(clock), .resetN(resetN), .issueValid(issueValid),
        .memReadFlag(memReadFlag), .memWriteFlag(memWriteFlag),
        .memToRegFlag(memToRegFlag), .regWriteIn(regWriteIn),
        .writeRegIn(writeRegIn), .aluResult(aluResult), .storeData(storeData),
        .stall(stall), .wbValid(wbValid), .wbData(wbData),
        .wbRegister(wbRegister), .wbRegWrite(wbRegWrite),
        .misalignedFlag(misalignedFlag)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic m2r, input logic rw,
                         input logic [4:0] rg, input logic [31:0] alu, input logic [31:0] sd);
        issueValid   = 1'b1;
        memReadFlag  = rd;
        memWriteFlag = wr;
        memToRegFlag = m2r;
        regWriteIn   = rw;
        writeRegIn   = rg;
        aluResult    = alu;
        storeData    = sd;
    endtask

    task automatic idle_inputs();
        issueValid   = 1'b0;
        memReadFlag  = 1'b0;
        memWriteFlag = 1'b0;
        memToRegFlag = 1'b0;
        regWriteIn   = 1'b0;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic m2r, input logic rw,
                         input logic [4:0] rg, input logic [31:0] alu, input logic [31:0] sd);
        drive(rd, wr, m2r, rw, rg, alu, sd);
        tick();
        idle_inputs();
    endtask

    // counts cycles with stall high after the accept edge, bounded
    task automatic wait_done(output int cnt);
        cnt = 0;
        while (stall && cnt < 20) begin
            cnt++;
            tick();
            if (wbValid && wbData === 32'd7) seen7 = 1'b1;
        end
    endtask

    initial begin
        resetN = 1'b0;
        idle_inputs();
        writeRegIn = '0;
        aluResult  = '0;
        storeData  = '0;
        seen7      = 1'b0;
        tick();
        tick();
        chk("rst_stall", stall, 0);
        chk("rst_wbValid", wbValid, 0);
        chk("rst_wbData", wbData, 0);
        chk("rst_wbRegWrite", wbRegWrite, 0);
        chk("rst_misaligned", misalignedFlag, 0);
        resetN = 1'b1;
        tick();
        chk("post_rst_wbValid", wbValid, 0);

        issue(0, 0, 0, 1, 5'd5, 32'd30, 0);
        chk("pt_stall", stall, 0);
        chk("pt_wbValid", wbValid, 1);
        chk("pt_wbData", wbData, 32'd30);
        chk("pt_wbRegister", wbRegister, 5);
        chk("pt_wbRegWrite", wbRegWrite, 1);
        tick();
        chk("pt_pulse_end", wbValid, 0);
        chk("pt_hold_data", wbData, 32'd30);

        issue(0, 1, 0, 0, 5'd0, 32'h10, 32'hDEADBEEF);
        chk("st_stall_first", stall, 1);
        chk("st_no_early_valid", wbValid, 0);
        wait_done(n);
        chk("st_stall_cycles", n, 3);
        chk("st_wbValid", wbValid, 1);
        chk("st_wbRegWrite", wbRegWrite, 0);
        chk("st_wbData", wbData, 32'h10);
        tick();
        chk("st_pulse_end", wbValid, 0);

        issue(1, 0, 1, 1, 5'd9, 32'h10, 0);
        wait_done(n);
        chk("ld_stall_cycles", n, 3);
        chk("ld_wbValid", wbValid, 1);
        chk("ld_wbData", wbData, 32'hDEADBEEF);
        chk("ld_wbRegister", wbRegister, 9);
        chk("ld_wbRegWrite", wbRegWrite, 1);
        tick();

        issue(1, 0, 1, 1, 5'd3, 32'h13, 0);
        chk("mis_stall", stall, 0);
        chk("mis_wbValid", wbValid, 1);
        chk("mis_flag", misalignedFlag, 1);
        chk("mis_wbRegWrite", wbRegWrite, 0);
        chk("mis_wbData", wbData, 32'h13);
        tick();
        chk("mis_flag_end", misalignedFlag, 0);

        issue(1, 0, 1, 1, 5'd4, 32'h410, 0);
        wait_done(n);
        chk("wrap_stall_cycles", n, 3);
        chk("wrap_wbData", wbData, 32'hDEADBEEF);
        tick();

        issue(0, 1, 0, 0, 5'd0, 32'h20, 32'h55);
        chk("rstmid_busy", stall, 1);
        tick();
        chk("rstmid_busy2", stall, 1);
        resetN = 1'b0;
        tick();
        chk("rstmid_stall", stall, 0);
        chk("rstmid_wbValid", wbValid, 0);
        resetN = 1'b1;
        tick();
        tick();
        tick();
        chk("rstmid_no_late_valid", wbValid, 0);
        issue(1, 0, 1, 1, 5'd6, 32'h20, 0);
        wait_done(n);
        chk("rstmid_ld20_valid", wbValid, 1);
        chk("rstmid_ld20_data", wbData, 32'h0);
        tick();
        issue(1, 0, 1, 1, 5'd7, 32'h10, 0);
        wait_done(n);
        chk("rstmid_ld10_data", wbData, 32'hDEADBEEF);
        tick();

        issue(1, 0, 1, 1, 5'd9, 32'h10, 0);
        chk("ign_busy", stall, 1);
        drive(0, 0, 0, 1, 5'd2, 32'd7, 0);
        tick();
        if (wbValid && wbData === 32'd7) seen7 = 1'b1;
        idle_inputs();
        wait_done(n);
        chk("ign_stall_cycles", n, 2);
        chk("ign_wbValid", wbValid, 1);
        chk("ign_wbData", wbData, 32'hDEADBEEF);
        chk("ign_wbRegister", wbRegister, 9);
        tick();
        if (wbValid && wbData === 32'd7) seen7 = 1'b1;
        tick();
        if (wbValid && wbData === 32'd7) seen7 = 1'b1;
        chk("ign_no_pulse_after", wbValid, 0);
        chk("ign_never_7", seen7, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the ALU.
- Consumes the ALU result (as an address or a pass-through value), the store operand and the memory control flags; owns a word-addressed data RAM with configurable wait states; produces registered write-back data for the register file.
- Multi-cycle accesses assert a stall to upstream; non-memory operations pass through in one cycle.

Parameters:
- DATA_WIDTH, 32, data and ALU result width.
- ADDR_WIDTH, 8, word-address bits; RAM depth is 2^ADDR_WIDTH words.
- WAIT_STATES, 2, extra cycles per RAM access (0 is legal).

Ports:
- clock  input  1  processor clock, rising edge.
- resetN  input  1  synchronous, active-low reset.
- issueValid  input  1  upstream operation present this cycle.
- memReadFlag  input  1  load operation.
- memWriteFlag  input  1  store operation.
- memToRegFlag  input  1  write-back selects RAM data (1) or ALU result (0).
- regWriteIn  input  1  operation writes a register.
- writeRegIn  input  5  destination register ID.
- aluResult  input  DATA_WIDTH  ALU result / byte address.
- storeData  input  DATA_WIDTH  store operand (readData2).
- stall  output  1  stage busy; upstream must hold; combinational from state.
- wbValid  output  1  one-cycle pulse: write-back fields valid.
- wbData  output  DATA_WIDTH  write-back value.
- wbRegister  output  5  write-back register ID.
- wbRegWrite  output  1  register-file write enable; qualified by wbValid.
- misalignedFlag  output  1  one-cycle pulse with wbValid on misaligned access.

Behaviour:
- Reset (resetN=0 at a rising edge):
  - state is IDLE, counter is 0.
  - wbValid, wbData, wbRegister, wbRegWrite and misalignedFlag are all 0.
  - Any pending access is aborted with no RAM write.
  - RAM contents are preserved across reset and are zero at time zero.
- States are IDLE and BUSY; stall = (state == BUSY).
- Accept rule:
  - An operation is accepted at a rising edge when state == IDLE and issueValid = 1.
  - issueValid while BUSY is ignored (neither queued nor latched).
- All wb* outputs and misalignedFlag are registered. In every cycle without a completion, wbValid and misalignedFlag are 0. wbData, wbRegister and wbRegWrite hold their last values.
- Word address = aluResult[ADDR_WIDTH+1:2]. Upper bits are ignored, so addresses wrap modulo the RAM size.
- Non-memory operation (memReadFlag = memWriteFlag = 0):
  - Completes at the accept edge; no stall.
  - Outputs: wbValid=1, wbData=aluResult, wbRegister=writeRegIn, wbRegWrite=regWriteIn.
- Misaligned memory operation (read or write flag set, aluResult[1:0] != 0):
  - Completes at the accept edge; no RAM access, no stall.
  - Outputs: wbValid=1, misalignedFlag=1, wbRegWrite=0, wbData=aluResult.
- Aligned memory operation:
  - At the accept edge: latch address, storeData, memToRegFlag, regWriteIn, writeRegIn and the read/write flags; state goes to BUSY; counter is loaded with WAIT_STATES.
  - In BUSY with counter != 0: counter decrements each edge.
  - In BUSY with counter == 0, at the edge: perform the access, state goes to IDLE, wbValid=1.
  - stall is high for exactly WAIT_STATES+1 cycles after the accept edge. Results appear after edge N+WAIT_STATES+1, where N is the accept edge.
  - A new operation can be accepted at the edge following the completion edge. Back-to-back issue gives one idle edge.
- Load completion:
  - wbData = RAM[addr] if memToRegFlag, else the latched aluResult.
  - wbRegWrite = latched regWriteIn; wbRegister = latched writeRegIn.
- Store completion: RAM[addr] = latched storeData, wbRegWrite=0, wbData=latched aluResult.
- memReadFlag and memWriteFlag both set:
  - The write is performed.
  - wbData returns the pre-write RAM contents (read-before-write).
  - wbRegWrite = latched regWriteIn.
- Reset asserted while BUSY: no RAM write and no wbValid pulse; stall drops after that edge.
- All arithmetic is unsigned. The counter is at least clog2(WAIT_STATES+1) bits, minimum 1.

Test Plan:
- Reset: hold resetN=0 for 2 edges, then release -> stall=0, wbValid=0, wbData=0, wbRegWrite=0, misalignedFlag=0.
- Pass-through: issue aluResult=30, writeRegIn=5, regWriteIn=1, no memory flags -> next cycle wbValid=1, wbData=30, wbRegister=5, wbRegWrite=1, stall never high.
- Store/load (WAIT_STATES=2), part 1: store 0xDEADBEEF to aluResult=0x10 -> stall high 3 cycles, then wbValid pulse with wbRegWrite=0.
- Store/load, part 2: then load 0x10 with memToRegFlag=1, writeRegIn=9 -> stall 3 cycles, wbData=0xDEADBEEF, wbRegister=9, wbRegWrite=1.
- Misaligned and wrap, part 1: load aluResult=0x13 -> next cycle misalignedFlag=1, wbRegWrite=0, no stall.
- Misaligned and wrap, part 2: load 0x410 -> wbData=0xDEADBEEF (wraps to word 4).
- Reset mid-store: store 0x55 to 0x20, drive resetN=0 on the 2nd BUSY cycle -> no wbValid, stall=0; after reset, a load of 0x20 returns 0 and a load of 0x10 still returns 0xDEADBEEF.
- Ignored issue: pulse issueValid with a pass-through op (aluResult=7) while stall=1 -> only the original access completes; no wbData=7 pulse ever appears.
